// File: rtl/dct_da_sequencer.sv
// dct_da_sequencer: sequences the bit-serial DA DCT engine over ping-pong sample banks.
// Ports: s_* sample stream in (valid/ready); eng_* engine control/data; m_* coefficient stream out
//        (valid/ready, m_last on the final index); busy = FSM not idle; blk_cnt = completed blocks;
//        err = sticky watchdog flag. Optional watchdog compiled in with `define DCT_SEQ_WDOG_EN.
// Reset is synchronous active-high on rst; everything is clocked by clk.
module dct_da_sequencer #(
    parameter int DW          = 15,
    parameter int OW          = 18,
    parameter int NSAMP       = 16,
    parameter int NCOEF       = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          eng_rst,
    output logic [DW-1:0] eng_data,
    input  logic          eng_done,
    input  logic [OW-1:0] eng_out,
    input  logic [2:0]    eng_k,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic [2:0]    m_idx,
    output logic          m_last,
    output logic          busy,
    output logic [15:0]   blk_cnt,
    output logic          err
);
    localparam int SW = $clog2(NSAMP);
    localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int CW = $clog2(NCOEF + 1);

    typedef enum logic [2:0] {IDLE, ERST, LOAD, RUN, WAITOUT} state_t;
    state_t state, state_nxt;

    logic [DW-1:0] bank [2][NSAMP];
    logic [1:0]    bank_full;
    logic          wr_bank, rd_bank;
    logic [SW-1:0] wr_ptr, ld_cnt;

    logic [OW-1:0] res_data [NCOEF];
    logic [2:0]    res_idx  [NCOEF];
    logic [CW-1:0] wr_cnt, rd_cnt;   // wr_cnt doubles as the done counter in RUN

    logic wr_fire, pop, load_last, cap, cap_last, drained, wdog_to;
    logic unused_eng_k;

    assign s_ready   = !bank_full[wr_bank];
    assign wr_fire   = s_valid && s_ready;
    assign load_last = (state == LOAD) && (ld_cnt == SW'(NSAMP - 1));
    // The engine index eng_k is not trusted for addressing; our own count is.
    assign cap       = (state == RUN) && eng_done;
    assign cap_last  = cap && (wr_cnt == CW'(NCOEF - 1));
    assign drained   = (rd_cnt == wr_cnt);
    assign m_valid   = (rd_cnt < wr_cnt);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? res_data[rd_cnt[IW-1:0]] : '0;
    assign m_idx     = m_valid ? res_idx[rd_cnt[IW-1:0]] : 3'd0;
    assign m_last    = m_valid && (res_idx[rd_cnt[IW-1:0]] == 3'(NCOEF - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        eng_rst   = 1'b1;
        case (state)
            IDLE:    if (bank_full[rd_bank] && drained) state_nxt = ERST;
            ERST:    state_nxt = LOAD;
            LOAD: begin
                eng_rst = 1'b0;
                if (load_last) state_nxt = RUN;
            end
            RUN: begin
                eng_rst = 1'b0;
                if (cap_last || wdog_to) state_nxt = WAITOUT;
            end
            // Engine sits in its terminal state here; hold it in reset until results drain.
            WAITOUT: if (drained) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Storage arrays carry no reset: contents are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_fire) bank[wr_bank][wr_ptr] <= s_data;
        if (cap) begin
            res_data[wr_cnt[IW-1:0]] <= eng_out;
            res_idx[wr_cnt[IW-1:0]]  <= 3'(wr_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_ptr    <= '0;
            ld_cnt    <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            eng_data  <= '0;
            blk_cnt   <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_ptr == SW'(NSAMP - 1)) begin
                    wr_ptr             <= '0;
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end

            // eng_data is registered one step ahead so sample n lines up with LOAD cycle n.
            case (state)
                ERST:    eng_data <= bank[rd_bank][ld_cnt];
                LOAD:    eng_data <= load_last ? '0 : bank[rd_bank][ld_cnt + 1'b1];
                default: eng_data <= '0;
            endcase

            if (state == LOAD) begin
                if (load_last) begin
                    ld_cnt             <= '0;
                    bank_full[rd_bank] <= 1'b0;   // never the bank being written
                    rd_bank            <= ~rd_bank;
                end else begin
                    ld_cnt <= ld_cnt + 1'b1;
                end
            end

            if (cap)      wr_cnt  <= wr_cnt + 1'b1;
            if (cap_last) blk_cnt <= blk_cnt + 16'd1;
            if (pop)      rd_cnt  <= rd_cnt + 1'b1;

            if ((state == WAITOUT) && drained) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            // Watchdog abort discards any unread partial results.
            if (wdog_to) begin
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
        end
    end

`ifdef DCT_SEQ_WDOG_EN
    logic [31:0] wdog;

    assign wdog_to = (state == RUN) && !eng_done && (wdog == 32'(WDOG_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
            err  <= 1'b0;
        end else begin
            if ((state != RUN) || eng_done) wdog <= '0;
            else                            wdog <= wdog + 32'd1;
            if (wdog_to) err <= 1'b1;
        end
    end

    assign unused_eng_k = ^eng_k;
`else
    assign wdog_to      = 1'b0;
    assign err          = 1'b0;
    assign unused_eng_k = (^eng_k) ^ (WDOG_CYCLES == 0);
`endif

endmodule

// File: tb/tb_dct_da_sequencer.sv
// tb_dct_da_sequencer: directed bench for dct_da_sequencer with an engine stub,
// an input-sample scoreboard checked at the engine port, and an output scoreboard
// checked by an independent monitor on the m_* stream.
module tb_dct_da_sequencer;
    localparam int DW = 15;
    localparam int OW = 18;
    localparam int NSAMP = 16;
    localparam int NCOEF = 4;
    localparam int WDOG = 64;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, eng_rst, eng_done, m_valid, m_ready, m_last, busy, err;
    logic [DW-1:0] s_data, eng_data;
    logic [OW-1:0] eng_out, m_data;
    logic [2:0]    eng_k, m_idx;
    logic [15:0]   blk_cnt;

    logic          stub_done, inj_done;
    logic [OW-1:0] stub_out, inj_out;
    logic [2:0]    stub_k;

    assign eng_done = stub_done | inj_done;
    assign eng_out  = inj_done ? inj_out : stub_out;
    assign eng_k    = inj_done ? 3'd0 : stub_k;

    dct_da_sequencer #(.DW(DW), .OW(OW), .NSAMP(NSAMP), .NCOEF(NCOEF), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .eng_rst(eng_rst), .eng_data(eng_data), .eng_done(eng_done), .eng_out(eng_out),
        .eng_k(eng_k), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx),
        .m_last(m_last), .busy(busy), .blk_cnt(blk_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OW-1:0] data;
        logic [2:0]    idx;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   samp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   blocks_loaded = 0;
    int   lasts_popped = 0;
    int   stub_ndone = 4;
    int   done_cyc = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Each block the stub sees yields coefficients 100,200,300,400.
    task automatic push_block();
        for (int k = 0; k < NCOEF; k++) begin
            exp_t e;
            e.data = OW'(100 * (k + 1));
            e.idx  = 3'(k);
            e.last = (k == NCOEF - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int n, input int base, output int stalls);
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + i);
            forever begin
                @(negedge clk);
                if (s_ready) break;
                stalls++;
                if (stalls > 5000) break;
            end
            if (stalls > 5000) begin
                chk("send_timeout", stalls, 0);
                break;
            end
            samp_q.push_back(base + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_eng_rst", 32'(eng_rst), 1);
        chk("rst_eng_data", 32'(eng_data), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_idx", 32'(m_idx), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_blk_cnt", 32'(blk_cnt), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        samp_q.delete();
        exp_q.delete();
        blocks_loaded = lasts_popped;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (t < 4000) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            t++;
        end
        chk("drain_timeout", int'(t < 4000), 1);
        @(posedge clk); #1;
    endtask

    // Engine stub: checks the reset pulse and the 16 presented samples, then emits dones.
    initial begin : stub
        int  erst_n;
        bit  aborted;
        stub_done = 1'b0; stub_out = '0; stub_k = '0;
        forever begin
            erst_n = 0;
            forever begin
                @(negedge clk);
                if (!rst && busy && !eng_rst) break;
                erst_n = (busy && eng_rst) ? erst_n + 1 : 0;
            end
            chk("erst_len", erst_n, 1);
            chk("load_after_drain", lasts_popped, blocks_loaded);
            aborted = 1'b0;
            for (int i = 0; i < NSAMP; i++) begin
                if (i > 0) @(negedge clk);
                if (eng_rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (samp_q.size() == 0) chk("eng_data_unexpected", 32'(eng_data), -1);
                else                    chk("eng_data", 32'(eng_data), samp_q.pop_front());
            end
            if (!aborted) begin
                blocks_loaded++;
                for (int d = 0; d < stub_ndone; d++) begin
                    repeat (20) @(posedge clk);
                    #1;
                    if (eng_rst) break;
                    stub_done = 1'b1;
                    stub_out  = OW'(100 * (d + 1));
                    stub_k    = 3'(d);
                    @(posedge clk);
                    done_cyc = cyc + 1;
                    #1 stub_done = 1'b0;
                end
            end
        end
    end

    // Output monitor: pops expected entries on each handshake and checks hold stability.
    initial begin : monitor
        bit            held;
        logic [OW-1:0] hd;
        logic [2:0]    hi;
        held = 1'b0; hd = '0; hi = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                chk("hold_valid", 32'(m_valid), 1);
                chk("hold_data", 32'(m_data), 32'(hd));
                chk("hold_idx", 32'(m_idx), 32'(hi));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("m_unexpected", 32'(m_data), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e.data));
                    chk("m_idx", 32'(m_idx), 32'(e.idx));
                    chk("m_last", 32'(m_last), 32'(e.last));
                end
                if (m_last) lasts_popped++;
            end
            held = m_valid && !m_ready;
            hd   = m_data;
            hi   = m_idx;
        end
    end

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int st;
        int t;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        inj_done = 1'b0; inj_out = '0;

        // 1: single block, samples 0..15
        do_reset();
        push_block();
        send(16, 0, st);
        wait_drain();
        chk("t1_blk_cnt", 32'(blk_cnt), 1);

        // 2: 32 back-to-back samples, no stalls
        do_reset();
        push_block(); push_block();
        send(32, 100, st);
        chk("t2_no_stall", st, 0);
        wait_drain();
        chk("t2_blk_cnt", 32'(blk_cnt), 2);

        // 3: downstream stall, then fill both banks
        do_reset();
        for (int b = 0; b < 4; b++) push_block();
        m_ready = 1'b0;
        send(16, 200, st);
        t = 0;
        while (t < 500) begin
            @(negedge clk);
            if (m_valid) break;
            t++;
        end
        chk("t3_valid_seen", int'(t < 500), 1);
        chk("t3_head_data", 32'(m_data), 100);
        repeat (50) @(negedge clk);
        chk("t3_hold_data", 32'(m_data), 100);
        chk("t3_hold_idx", 32'(m_idx), 0);
        @(posedge clk); #1;
        send(32, 300, st);
        chk("t3_no_stall_32", st, 0);
        @(negedge clk);
        chk("t3_s_ready_full", 32'(s_ready), 0);
        @(posedge clk); #1;
        fork
            send(16, 400, st);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("t3_parked", 32'(busy && eng_rst), 1);
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t3_blk_cnt", 32'(blk_cnt), 4);

        // 4: reset in the middle of LOAD, then a clean block
        do_reset();
        send(16, 500, st);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (busy && !eng_rst) break;
            t++;
        end
        chk("t4_load_seen", int'(t < 100), 1);
        repeat (6) @(negedge clk);
        do_reset();
        push_block();
        send(16, 600, st);
        wait_drain();
        chk("t4_blk_cnt", 32'(blk_cnt), 1);

        // 5: stray done pulse while idle
        chk("t5_idle", 32'(busy), 0);
        inj_done = 1'b1; inj_out = OW'(999);
        @(posedge clk); #1;
        inj_done = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("t5_no_valid", 32'(m_valid), 0);
        end
        @(posedge clk); #1;
        push_block();
        send(16, 700, st);
        wait_drain();
        chk("t5_blk_cnt", 32'(blk_cnt), 2);

`ifdef DCT_SEQ_WDOG_EN
        // 6: engine stalls after two dones; watchdog aborts the block
        do_reset();
        stub_ndone = 2;
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e.data = OW'(100 * (k + 1));
            e.idx  = 3'(k);
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        send(16, 800, st);
        t = 0;
        while (t < 2000) begin
            @(negedge clk);
            if (err) break;
            t++;
        end
        chk("t6_err_set", 32'(err), 1);
        chk("t6_err_delay", cyc - done_cyc, WDOG);
        repeat (4) @(negedge clk);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_no_valid", 32'(m_valid), 0);
        chk("t6_blk_cnt", 32'(blk_cnt), 0);
        chk("t6_err_sticky", 32'(err), 1);
        chk("t6_exp_empty", exp_q.size(), 0);
        stub_ndone = 4;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dct_da_sequencer.md
Name: dct_da_sequencer

Overview:
- Controller for the bit-serial distributed-arithmetic DCT engine (16-sample load, butterfly, 16-bit DA accumulation, one done pulse per coefficient k, then a terminal state that only a reset clears).
- Accepts a valid/ready sample stream into a ping-pong block buffer.
- Per block: resets the engine, feeds it 16 samples on consecutive cycles, captures each coefficient on its done pulse, and streams the results out with valid/ready.
- Sits between the sample source and the downstream quantiser.

Parameters:
DW, 15, sample width (engine input width)
OW, 18, coefficient width (engine output width)
NSAMP, 16, samples per block (power of 2)
NCOEF, 4, done pulses per block before the engine reaches its terminal state
WDOG_CYCLES, 1024, watchdog limit in RUN (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  DW  input sample
eng_rst  out  1  synchronous reset to engine
eng_data  out  DW  sample presented to engine
eng_done  in  1  engine coefficient-done pulse
eng_out  in  OW  engine coefficient value, valid when eng_done=1
eng_k  in  3  engine coefficient index
m_valid  out  1  result valid
m_ready  in  1  result accepted
m_data  out  OW  coefficient
m_idx  out  3  coefficient index 0..NCOEF-1
m_last  out  1  high with idx NCOEF-1
busy  out  1  FSM not in IDLE
blk_cnt  out  16  completed blocks, wraps at 65535
err  out  1  sticky watchdog error (0 when feature is off)

Behaviour:
- Reset values: s_ready=1, eng_rst=1, eng_data=0, m_valid=0, m_data=0, m_idx=0, m_last=0, busy=0, blk_cnt=0, err=0. Both banks empty, write bank 0, result buffer empty.
- Input side:
  - A sample is written on s_valid&&s_ready to wr_bank[wr_ptr]. wr_ptr increments; at NSAMP-1 the bank is marked full, wr_ptr wraps to 0 and wr_bank toggles.
  - s_ready=0 when the target bank is full.
- FSM states: IDLE, ERST, LOAD, RUN, WAITOUT.
  - IDLE: eng_rst=1. Move to ERST when rd_bank is full and the result buffer is empty.
  - ERST: eng_rst=1 for exactly 1 cycle, then LOAD.
  - LOAD: eng_rst=0. For NSAMP consecutive cycles, eng_data = rd_bank[n] for n=0..NSAMP-1 (registered, so sample 0 is valid the first LOAD cycle). On the last cycle, clear the rd_bank full flag, toggle rd_bank, then go to RUN. The engine therefore sees exactly the reset cycle followed by 16 consecutive sample cycles.
  - RUN: on each eng_done=1 cycle, write {eng_out, cnt} to result[cnt], where cnt counts 0..NCOEF-1; eng_k is ignored for addressing. After the NCOEF-th done, go to WAITOUT and increment blk_cnt.
  - WAITOUT: eng_rst=1 (parks the terminal-state engine). Go to IDLE when the result buffer drains.
- Output side:
  - result[] is read in order; m_valid is high while unread entries exist.
  - An entry pops on m_valid&&m_ready. m_data and m_idx hold stable while m_valid&&!m_ready.
  - Results may drain while RUN is still capturing; read pointer never passes write pointer.
- Boundaries:
  - eng_done while not in RUN: ignored.
  - Input keeps filling the other bank during LOAD/RUN/WAITOUT.
  - Simultaneous bank-full clear (LOAD end) and input write into the same bank cannot occur, because the banks differ.
  - Back-to-back blocks: next ERST no earlier than the cycle after the last result pops.
  - rst mid-block: all state returns to reset values, partial banks and results are discarded, and eng_rst=1 on the next cycle.

Optional Feature:
- Macro: DCT_SEQ_WDOG_EN.
- Defined: a counter runs in RUN and clears on each eng_done. On reaching WDOG_CYCLES, set err=1 (sticky until rst), drop the partial results, and go to WAITOUT with the result buffer cleared. blk_cnt is not incremented.
- Undefined: no counter, err tied 0, RUN waits indefinitely.

Test Plan:
- After rst, stream samples 0..15 with s_valid constant and an engine stub that pulses done 20 cycles apart with out=100,200,300,400 → eng_rst high one cycle, then eng_data 0..15 on 16 consecutive cycles; m outputs (100,0),(200,1),(300,2),(400,3,last); blk_cnt=1.
- Stream 32 samples back-to-back → s_ready stays 1 for all 32; second block's LOAD starts only after result idx 3 of block 1 pops; blk_cnt=2.
- Hold m_ready=0 for 50 cycles during block 1 → m_data=100 stable; 48 further samples → s_ready=0 after the second bank fills; no second ERST until drain.
- Assert rst at LOAD sample 7 → next cycle all outputs at reset values; a fresh 16 samples produce a complete block with idx 0..3.
- Stub emits eng_done in IDLE with out=999 → no m_valid.
- With DCT_SEQ_WDOG_EN and WDOG_CYCLES=64, stub gives 2 dones then stops → err=1 at 64 cycles after the second done, no m_valid for the dropped entries, blk_cnt unchanged, FSM back in IDLE.
